// File: rtl/inference_frame_streamer.sv
// Captures a received frame plus sender addresses and streams pixel bytes 1..N-1 over valid/ready.
// Optional macro FRAME_DROP_COUNT_EN adds a saturating DROP_COUNT of rejected frames.
module inference_frame_streamer #(
    parameter int USER_DATA_BYTES = 785,
    parameter int COUNTER_WIDTH   = 16
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [USER_DATA_BYTES*8-1:0] DATA_FRAME,
    input  logic [31:0]                  SRC_IP_ADDRESS,
    input  logic [47:0]                  SRC_MAC_ADDRESS,
    input  logic                         FRAME_READY,
    output logic [7:0]                   FRAME_METADATA,
    output logic [31:0]                  FRAME_SRC_IP,
    output logic [47:0]                  FRAME_SRC_MAC,
    output logic [7:0]                   PIXEL_DATA,
    output logic                         PIXEL_VALID,
    input  logic                         PIXEL_READY,
    output logic                         PIXEL_LAST,
    input  logic                         RESULT_DONE,
    output logic                         FRAME_BUSY,
    output logic                         FRAME_DROPPED
`ifdef FRAME_DROP_COUNT_EN
    ,
    output logic [COUNTER_WIDTH-1:0]     DROP_COUNT
`endif
);

    localparam int IDX_W = $clog2(USER_DATA_BYTES);
    localparam logic [COUNTER_WIDTH-1:0] LAST_IDX = COUNTER_WIDTH'(USER_DATA_BYTES - 1);
    localparam logic [COUNTER_WIDTH-1:0] FIRST_IDX = COUNTER_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [COUNTER_WIDTH-1:0]       idx_q, idx_d;
    logic [USER_DATA_BYTES*8-1:0]   frame_q;
    logic [31:0]                    ip_q;
    logic [47:0]                    mac_q;
    logic                           dropped_q;
    logic [7:0]                     frame_bytes [USER_DATA_BYTES];
    logic [IDX_W-1:0]               idx_sel;
    logic                           accept;
    logic                           drop;
    logic                           fire;
    logic                           at_last;

    // A frame arriving with RESULT_DONE in WAIT replaces the finished one without passing through IDLE.
    assign accept  = FRAME_READY && ((state_q == S_IDLE) || ((state_q == S_WAIT) && RESULT_DONE));
    assign drop    = FRAME_READY && !accept;
    assign fire    = (state_q == S_STREAM) && PIXEL_READY;
    assign at_last = (idx_q == LAST_IDX);
    assign idx_sel = idx_q[IDX_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < USER_DATA_BYTES; gi++) begin : g_bytes
            assign frame_bytes[gi] = frame_q[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge ACLK) begin
        if (!ARESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (fire && at_last) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (accept)           state_d = S_STREAM;
                else if (RESULT_DONE) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        PIXEL_VALID = (state_q == S_STREAM);
        PIXEL_LAST  = PIXEL_VALID && at_last;
        PIXEL_DATA  = PIXEL_VALID ? frame_bytes[idx_sel] : 8'h00;
        FRAME_BUSY  = (state_q != S_IDLE);
    end

    // The index wraps back to 1 on the final beat so it never leaves 1..N-1.
    always_comb begin
        idx_d = idx_q;
        if (accept) begin
            idx_d = FIRST_IDX;
        end else if (fire) begin
            idx_d = at_last ? FIRST_IDX : idx_q + FIRST_IDX;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESET) begin
            idx_q     <= FIRST_IDX;
            frame_q   <= '0;
            ip_q      <= '0;
            mac_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            dropped_q <= drop;
            if (accept) begin
                frame_q <= DATA_FRAME;
                ip_q    <= SRC_IP_ADDRESS;
                mac_q   <= SRC_MAC_ADDRESS;
            end
        end
    end

    assign FRAME_METADATA = frame_bytes[0];
    assign FRAME_SRC_IP   = ip_q;
    assign FRAME_SRC_MAC  = mac_q;
    assign FRAME_DROPPED  = dropped_q;

`ifdef FRAME_DROP_COUNT_EN
    logic [COUNTER_WIDTH-1:0] drop_cnt_q;

    always_ff @(posedge ACLK) begin
        if (!ARESET) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + FIRST_IDX;
        end
    end

    assign DROP_COUNT = drop_cnt_q;
`endif

endmodule

// File: tb/tb_inference_frame_streamer.sv
// Scoreboard bench for inference_frame_streamer: random frames and backpressure against a byte-array model.
`timescale 1ns/1ps
module tb_inference_frame_streamer;
    localparam int N   = 785;
    localparam int CW  = 16;
    localparam int SN  = 4;
    localparam int SCW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            aresetn;
    logic [N*8-1:0]  data_frame;
    logic [31:0]     ip_in;
    logic [47:0]     mac_in;
    logic            frame_ready;
    logic [7:0]      meta;
    logic [31:0]     src_ip;
    logic [47:0]     src_mac;
    logic [7:0]      pdata;
    logic            pvalid;
    logic            pready;
    logic            plast;
    logic            result_done;
    logic            busy;
    logic            dropped;
`ifdef FRAME_DROP_COUNT_EN
    logic [CW-1:0]   drop_count;
`endif

    logic [SN*8-1:0] s_data_frame;
    logic            s_frame_ready;
    logic [7:0]      s_meta;
    logic [31:0]     s_src_ip;
    logic [47:0]     s_src_mac;
    logic [7:0]      s_pdata;
    logic            s_pvalid;
    logic            s_plast;
    logic            s_busy;
    logic            s_dropped;
`ifdef FRAME_DROP_COUNT_EN
    logic [SCW-1:0]  s_drop_count;
`endif

    inference_frame_streamer #(.USER_DATA_BYTES(N), .COUNTER_WIDTH(CW)) dut (
        .ACLK(clk), .ARESET(aresetn), .DATA_FRAME(data_frame),
        .SRC_IP_ADDRESS(ip_in), .SRC_MAC_ADDRESS(mac_in), .FRAME_READY(frame_ready),
        .FRAME_METADATA(meta), .FRAME_SRC_IP(src_ip), .FRAME_SRC_MAC(src_mac),
        .PIXEL_DATA(pdata), .PIXEL_VALID(pvalid), .PIXEL_READY(pready), .PIXEL_LAST(plast),
        .RESULT_DONE(result_done), .FRAME_BUSY(busy), .FRAME_DROPPED(dropped)
`ifdef FRAME_DROP_COUNT_EN
        , .DROP_COUNT(drop_count)
`endif
    );

    inference_frame_streamer #(.USER_DATA_BYTES(SN), .COUNTER_WIDTH(SCW)) dut_s (
        .ACLK(clk), .ARESET(aresetn), .DATA_FRAME(s_data_frame),
        .SRC_IP_ADDRESS(32'h0), .SRC_MAC_ADDRESS(48'h0), .FRAME_READY(s_frame_ready),
        .FRAME_METADATA(s_meta), .FRAME_SRC_IP(s_src_ip), .FRAME_SRC_MAC(s_src_mac),
        .PIXEL_DATA(s_pdata), .PIXEL_VALID(s_pvalid), .PIXEL_READY(1'b0), .PIXEL_LAST(s_plast),
        .RESULT_DONE(1'b0), .FRAME_BUSY(s_busy), .FRAME_DROPPED(s_dropped)
`ifdef FRAME_DROP_COUNT_EN
        , .DROP_COUNT(s_drop_count)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] sb [$];
    int beats = 0;
    int drops_seen = 0;
    int s_drops = 0;
    int ready_mode = 0;

    logic [7:0]  frm [N];
    logic [31:0] cur_ip, exp_ip;
    logic [47:0] cur_mac, exp_mac;
    logic [7:0]  exp_meta;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every presented beat must match the scoreboard head; it is consumed only on a handshake.
    always @(negedge clk) begin
        if (dropped) drops_seen++;
        if (s_dropped) s_drops++;
        if (pvalid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL beat_unexpected: got data 0x%0h with no beat expected", pdata);
            end else if (pdata !== sb[0][7:0] || plast !== sb[0][8]) begin
                n_err++;
                $display("FAIL beat: got data 0x%0h last %0b expected data 0x%0h last %0b",
                         pdata, plast, sb[0][7:0], sb[0][8]);
            end else if (pready) begin
                void'(sb.pop_front());
                beats++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        pready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 2) != 0);
    end

    task automatic random_frame();
        for (int k = 0; k < N; k++) frm[k] = 8'($urandom);
        cur_ip  = $urandom;
        cur_mac = {16'($urandom), 32'($urandom)};
    endtask

    task automatic offer_frame(input bit expect_accept, input bit with_done);
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) data_frame[k*8 +: 8] = frm[k];
        ip_in       = cur_ip;
        mac_in      = cur_mac;
        frame_ready = 1'b1;
        result_done = with_done;
        if (expect_accept) begin
            for (int k = 1; k < N; k++) sb.push_back({(k == N - 1), frm[k]});
            exp_meta = frm[0];
            exp_ip   = cur_ip;
            exp_mac  = cur_mac;
        end
        if (with_done) begin
            @(negedge clk);
            check("busy_before_swap", busy, 1);
        end
        @(posedge clk); #1;
        frame_ready = 1'b0;
        result_done = 1'b0;
        @(negedge clk);
        check("frame_dropped", dropped, !expect_accept);
        if (expect_accept) begin
            check("busy_after_accept", busy, 1);
            check("valid_after_accept", pvalid, 1);
        end
    endtask

    task automatic wait_stream_done(input string name, input int bound);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while ((sb.size() != 0 || pvalid) && i < bound);
        n_cmp++;
        if (sb.size() != 0 || pvalid) begin
            n_err++;
            $display("FAIL %s: got %0d beats outstanding after %0d cycles, expected 0", name, sb.size(), i);
        end
    endtask

    task automatic check_captured(input string name);
        check({name, "_meta"}, meta, exp_meta);
        check({name, "_ip"}, src_ip, exp_ip);
        check({name, "_mac"}, src_mac, exp_mac);
    endtask

    task automatic pulse_result_done();
        @(posedge clk); #1 result_done = 1'b1;
        @(posedge clk); #1 result_done = 1'b0;
        @(negedge clk);
        check("busy_after_done", busy, 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid"}, pvalid, 0);
        check({name, "_last"}, plast, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_dropped"}, dropped, 0);
        check({name, "_pdata"}, pdata, 0);
        check({name, "_meta"}, meta, 0);
        check({name, "_ip"}, src_ip, 0);
        check({name, "_mac"}, src_mac, 0);
`ifdef FRAME_DROP_COUNT_EN
        check({name, "_drop_count"}, drop_count, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int t;
        aresetn       = 1'b0;
        frame_ready   = 1'b1;
        result_done   = 1'b0;
        data_frame    = '1;
        ip_in         = '1;
        mac_in        = '1;
        s_data_frame  = '0;
        s_frame_ready = 1'b0;
        exp_meta = '0; exp_ip = '0; exp_mac = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        aresetn     = 1'b1;
        frame_ready = 1'b0;
        @(negedge clk);
        check("reset_frame_not_taken", busy, 0);
        check("reset_frame_not_dropped", dropped, 0);

        // Fixed pattern at full throughput.
        frm[0] = 8'hA5;
        for (int k = 1; k < N; k++) frm[k] = 8'(k);
        cur_ip = 32'h0A000002; cur_mac = 48'h001122334455;
        ready_mode = 1;
        offer_frame(1, 0);
        cyc = 0;
        while (pvalid && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        check("throughput_cycles", cyc, N - 1);
        check("beats_left_a", sb.size(), 0);
        check_captured("frame_a");

        // Rejected frame in WAIT_RESULT.
        random_frame();
        offer_frame(0, 0);
        @(negedge clk);
        check("dropped_single_pulse", dropped, 0);
        check_captured("after_drop_wait");
        pulse_result_done();

        // Same pattern under random backpressure, with a rejected frame mid-stream.
        frm[0] = 8'hA5;
        for (int k = 1; k < N; k++) frm[k] = 8'(k);
        cur_ip = 32'h0A000002; cur_mac = 48'h001122334455;
        ready_mode = 2;
        offer_frame(1, 0);
        repeat (200) @(negedge clk);
        random_frame();
        offer_frame(0, 0);
        wait_stream_done("backpressure_stream", 5000);
        check_captured("after_drop_stream");
        check("drop_pulses", drops_seen, 2);
`ifdef FRAME_DROP_COUNT_EN
        check("drop_count_two", drop_count, 2);
`endif

        // RESULT_DONE together with a new frame: swap straight into STREAM.
        random_frame();
        offer_frame(1, 1);
        check_captured("swap");
        wait_stream_done("swap_stream", 5000);
        check("drop_pulses_after_swap", drops_seen, 2);
        pulse_result_done();

        // Reset partway through a frame.
        random_frame();
        beats = 0;
        offer_frame(1, 0);
        t = 0;
        while (beats < 100 && t < 3000) begin
            t++;
            @(negedge clk);
        end
        check("beats_before_reset", beats >= 100, 1);
        @(posedge clk); #1;
        ready_mode = 0;
        aresetn    = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        @(negedge clk);
        check_all_zero("midstream_reset");
        @(posedge clk); #1 aresetn = 1'b1;

        random_frame();
        ready_mode = 1;
        offer_frame(1, 0);
        wait_stream_done("post_reset_stream", 2000);
        check_captured("post_reset");
        pulse_result_done();
        ready_mode = 0;

        // Small instance: hold it stalled in STREAM and reject 20 frames.
        s_data_frame = {8'h33, 8'h22, 8'h11, 8'h5C};
        @(posedge clk); #1 s_frame_ready = 1'b1;
        @(posedge clk); #1;
        s_data_frame = {8'hEE, 8'hDD, 8'hCC, 8'hBB};
        repeat (20) @(posedge clk);
        #1 s_frame_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("small_drop_pulses", s_drops, 20);
        check("small_stalled_valid", s_pvalid, 1);
        check("small_stalled_data", s_pdata, 8'h11);
        check("small_meta", s_meta, 8'h5C);
`ifdef FRAME_DROP_COUNT_EN
        check("small_drop_count_sat", s_drop_count, 4'hF);
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
